multi_cycle_control: RTL

- Multi-cycle sequencer for the MIPS-subset CPU. It replaces single-cycle decode with a state machine that steps each instruction through IF/ID/EXE/MEM/WB.
- Drives the same datapath control lines per state: PC, IR, register file, ALU, data memory. Adds IR load enable, halt status and a retired-instruction counter.
- Sits between the IR opcode field and the datapath muxes/write enables.

---
 rtl/cpu_defs.sv | 46 ++++
 rtl/op_decode.sv | 45 ++++
 rtl/multi_cycle_control.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcodes, ALU op codes, sequencer states.
// Used by the multi-cycle sequencer and the single-cycle decoder.
package cpu_defs;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_ORI  = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_OR   = 6'b010010;
  localparam logic [5:0] OP_MOVE = 6'b100000;
  localparam logic [5:0] OP_SW   = 6'b100110;
  localparam logic [5:0] OP_LW   = 6'b100111;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;

  localparam int CNT_W = 32;

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b111
  } state_e;

  function automatic logic op_known(input logic [5:0] op);
    logic k;
    k = 1'b0;
    case (op)
      OP_ADD, OP_ADDI, OP_SUB,
      OP_ORI, OP_AND, OP_OR,
      OP_MOVE, OP_SW, OP_LW,
      OP_BEQ, OP_HALT: k = 1'b1;
      default:         k = 1'b0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/op_decode.sv
// Opcode to datapath control decode (combinational).
// op -> alu_src_b, ext_sel, reg_out, alu_m2reg, alu_op.
module op_decode
  import cpu_defs::*;
(
  input  logic [5:0] op,
  output logic       alu_src_b,
  output logic       ext_sel,
  output logic       reg_out,
  output logic       alu_m2reg,
  output logic [2:0] alu_op
);

  always_comb begin
    alu_src_b = 1'b0;
    ext_sel   = 1'b1;
    reg_out   = 1'b1;
    alu_m2reg = 1'b0;
    alu_op    = ALU_ADD;
    case (op)
      OP_ADDI: begin
        alu_src_b = 1'b1;
        reg_out   = 1'b0;
      end
      OP_SUB: alu_op = ALU_SUB;
      OP_ORI: begin
        alu_src_b = 1'b1;
        ext_sel   = 1'b0;
        reg_out   = 1'b0;
        alu_op    = ALU_OR;
      end
      OP_AND: alu_op = ALU_AND;
      OP_OR:  alu_op = ALU_OR;
      OP_SW:  alu_src_b = 1'b1;
      OP_LW: begin
        alu_src_b = 1'b1;
        reg_out   = 1'b0;
        alu_m2reg = 1'b1;
      end
      OP_BEQ: alu_op = ALU_SUB;
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle IF/ID/EXE/MEM/WB sequencer driving datapath controls.
// In: CLK, Reset(n), operation, zero. Out: enables, muxes, ALUOp, halted, state_o, instr_count.
module multi_cycle_control
  import cpu_defs::*;
(
  input  logic             CLK,
  input  logic             Reset,
  input  logic [5:0]       operation,
  input  logic             zero,
  output logic             PCWre,
  output logic             IRWre,
  output logic             ALUSrcB,
  output logic             ALUM2Reg,
  output logic             RegWre,
  output logic             InsMemRW,
  output logic             DataMemRW,
  output logic             ExtSel,
  output logic             PCSrc,
  output logic             RegOut,
  output logic [2:0]       ALUOp,
  output logic             halted,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       dec_src_b, dec_ext, dec_reg_out, dec_m2reg;
  logic [2:0] dec_alu_op;

  logic       pc_we, ir_we, reg_we, dm_we;
  logic       src_b, ext, m2reg, reg_out, pc_src, hlt;
  logic [2:0] alu_op;

  op_decode u_dec (
    .op        (op_q),
    .alu_src_b (dec_src_b),
    .ext_sel   (dec_ext),
    .reg_out   (dec_reg_out),
    .alu_m2reg (dec_m2reg),
    .alu_op    (dec_alu_op)
  );

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q <= S_IF;
      op_q    <= 6'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_q_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_q_d  = op_q;
    pc_we   = 1'b0;
    ir_we   = 1'b0;
    reg_we  = 1'b0;
    dm_we   = 1'b0;
    src_b   = 1'b0;
    ext     = 1'b1;
    m2reg   = 1'b0;
    reg_out = 1'b0;
    pc_src  = 1'b0;
    hlt     = 1'b0;
    alu_op  = ALU_ADD;
    unique case (state_q)
      S_IF: begin
        ir_we   = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        op_q_d = operation;
        if (operation == OP_HALT) begin
          state_d = S_HALT;
        end else if (!op_known(operation)) begin
          // unknown opcode retires as a NOP
          pc_we   = 1'b1;
          state_d = S_IF;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        src_b  = dec_src_b;
        ext    = dec_ext;
        alu_op = dec_alu_op;
        if (op_q == OP_BEQ) begin
          pc_src  = zero;
          pc_we   = 1'b1;
          state_d = S_IF;
        end else if (op_q == OP_SW || op_q == OP_LW) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        src_b  = dec_src_b;
        ext    = dec_ext;
        alu_op = dec_alu_op;
        if (op_q == OP_SW) begin
          dm_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_IF;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        src_b   = dec_src_b;
        ext     = dec_ext;
        alu_op  = dec_alu_op;
        m2reg   = dec_m2reg;
        reg_out = dec_reg_out;
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        state_d = S_IF;
      end
      S_HALT: begin
        hlt     = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_IF;
    endcase
  end

  // reset low suppresses every write pulse combinationally
  always_comb begin
    PCWre     = Reset & pc_we;
    IRWre     = Reset & ir_we;
    RegWre    = Reset & reg_we;
    DataMemRW = Reset & dm_we;
    ALUSrcB   = Reset & src_b;
    ALUM2Reg  = Reset & m2reg;
    RegOut    = Reset & reg_out;
    PCSrc     = Reset & pc_src;
    halted    = Reset & hlt;
    ExtSel    = ~Reset | ext;
    ALUOp     = Reset ? alu_op : ALU_ADD;
    InsMemRW  = 1'b0;
    cnt_d     = cnt_q + CNT_W'(PCWre);
  end

  assign state_o     = state_q;
  assign instr_count = cnt_q;

endmodule
